// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and load status of the program loader
interface imem_loader_if #(parameter int ADDR_W = 6);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into instruction words and writes them from word 0, holding the CPU in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA, FLUSH,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERROR
  } state_t;
  state_t            state, nxt;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        bcnt;
  logic [23:0]       asm_r;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              rdy_st, acc, last, word_end, oversize;
  logic [15:0]       n_lo;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xsum;
  assign rdy_st = state inside {CNT_HI, CNT_LO, DATA, CHK};
`else
  assign rdy_st = state inside {CNT_HI, CNT_LO, DATA};
`endif
  assign bus.in_ready   = reset && rdy_st;
  assign acc            = bus.in_valid && bus.in_ready;
  assign n_lo           = {cnt[15:8], bus.in_data};
  assign oversize       = 32'(n_lo) > (32'd1 << ADDR_W);
  assign last           = 16'(widx) == cnt - 16'd1;
  assign word_end       = acc && state == DATA && bcnt == 2'd3;
  assign bus.imem_we    = we;
  assign bus.imem_waddr = waddr;
  assign bus.imem_wdata = wdata;
  assign bus.done       = state == DONE;
  assign bus.error      = state == ERROR;
  assign bus.cpu_reset  = state != DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= CNT_HI;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      CNT_HI:  nxt = acc ? CNT_LO : CNT_HI;
      CNT_LO:  nxt = !acc ? CNT_LO : n_lo == 16'd0 ? DONE : oversize ? ERROR : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA:    nxt = word_end && last ? CHK : DATA;
      CHK:     nxt = !acc ? CHK : bus.in_data == xsum ? DONE : ERROR;
`else
      DATA:    nxt = word_end && last ? FLUSH : DATA;
`endif
      FLUSH:   nxt = DONE;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      widx  <= '0;
      bcnt  <= '0;
      asm_r <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= word_end;
      if (acc && state == CNT_HI) cnt[15:8] <= bus.in_data;
      if (acc && state == CNT_LO) cnt[7:0] <= bus.in_data;
      if (acc && state == DATA) begin
        asm_r <= {asm_r[15:0], bus.in_data};
        bcnt  <= bcnt + 2'd1;
      end
      if (word_end) begin
        waddr <= widx;
        wdata <= {asm_r, bus.in_data};
        widx  <= last ? widx : widx + 1'b1;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) xsum <= '0;
    else if (acc && state == DATA) xsum <= xsum ^ bus.in_data;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream bench with a write scoreboard checked by an independent monitor.
module tb_imem_loader;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;
  typedef struct {logic [AW-1:0] addr; logic [31:0] data; int cyc;} wr_t;
  logic clk = 0;
  logic reset = 0;
  int compared = 0, mismatched = 0, cyc = 0;
  wr_t exp_q[$];
  wr_t e;
  logic [31:0] img[$];
  logic [31:0] mem[DEPTH];
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW)) dut(.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask
  always @(negedge clk) if (reset) begin
    if (bus.imem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.imem_waddr), 32'hffffffff);
      else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(bus.imem_waddr), 32'(e.addr));
        chk("wdata", bus.imem_wdata, e.data);
        chk("we_cycle", cyc, e.cyc);
      end
    end
    if (bus.done && bus.error) chk("done_and_error", 1, 0);
  end
  task automatic do_reset();
    bus.in_valid = 0;
    reset = 0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_waddr", 32'(bus.imem_waddr), 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int mode, output int k);
    bit got;
    int gap = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 3));
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1;
    bus.in_data = b;
    k = -1;
    for (int t = 0; t < 20 && k < 0; t++) begin
      @(negedge clk) got = bus.in_ready;
      @(posedge clk);
      #1;
      if (got) k = cyc;
    end
    bus.in_valid = 0;
    if (k < 0) chk("accept_timeout", 0, 1);
  endtask
  task automatic send_stream(input int n, input int mode, input bit good, output int k);
    logic [31:0] w;
    logic [7:0] xs = 0;
    logic [7:0] by;
    logic [15:0] hdr = 16'(n);
    send_byte(hdr[15:8], mode, k);
    send_byte(hdr[7:0], mode, k);
    if (n == 0 || n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        by = w[31-8*j -: 8];
        xs ^= by;
        send_byte(by, mode, k);
        if (j == 3) exp_q.push_back('{AW'(i), w, k});
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(good ? xs : xs ^ 8'h01, mode, k);
`endif
  endtask
  task automatic run(input int n, input int mode, input bit good);
    int k;
    bit flush;
    bit ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    flush = 0;
    ok = n <= DEPTH && (n == 0 || good);
`else
    flush = n > 0 && n <= DEPTH;
    ok = n <= DEPTH;
`endif
    send_stream(n, mode, good, k);
    if (flush) begin
      @(negedge clk);
      chk("done_before_release", bus.done, 0);
      chk("cpu_reset_before_release", bus.cpu_reset, 1);
    end
    @(negedge clk);
    chk("done", bus.done, 32'(ok));
    chk("error", bus.error, 32'(!ok));
    chk("cpu_reset", bus.cpu_reset, 32'(!ok));
    chk("in_ready_final", bus.in_ready, 0);
    chk("pending_writes", exp_q.size(), 0);
    if (n <= DEPTH) for (int i = 0; i < n; i++) chk($sformatf("mem[%0d]", i), mem[i], img[i]);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    bus.in_valid = 0;
    bus.in_data = 0;
    do_reset();
    img = '{32'h20020001, 32'h20030001, 32'h00431020};
    run(3, 0, 1);
    do_reset();
    run(3, 1, 1);
    do_reset();
    img = {};
    run(0, 0, 1);
    do_reset();
    run(DEPTH + 1, 0, 1);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      img = {};
      for (int i = int'($urandom_range(1, 8)); i > 0; i--) img.push_back($urandom);
      run(img.size(), 2, 1);
    end
    do_reset();
    img = {};
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run(DEPTH, 0, 1);
    do_reset();
    img = '{32'hcafef00d, 32'h0badbeef};
    send_byte(8'h00, 0, k);
    send_byte(8'h02, 0, k);
    for (int j = 0; j < 6; j++) begin
      send_byte(j < 4 ? img[0][31-8*j -: 8] : img[1][31-8*(j-4) -: 8], 0, k);
      if (j == 3) exp_q.push_back('{AW'(0), img[0], k});
    end
    chk("midload_pending", exp_q.size(), 0);
    do_reset();
    img = '{32'h8c220004};
    run(1, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    img = '{32'h12345678};
    run(1, 0, 1);
    do_reset();
    run(1, 0, 0);
    chk("chk_bad_mem0", mem[0], 32'h12345678);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the single-cycle MIPS processor: the synthesizable counterpart of the bench-side `$readmemh` preload. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them sequentially into instruction memory starting at word 0. The processor is held in reset until the complete image has been written.

## Interface
Parameters:
- `ADDR_W`, default 6: instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_data`  in  8  stream byte.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_waddr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word of the write.
- `cpu_reset`  out  1  active-high reset to the processor; 1 until the load completes.
- `done`  out  1  load completed successfully; sticky until `reset`.
- `error`  out  1  load failed; sticky until `reset`.

## Operation
Stream format:
- Header: 16-bit word count N, high byte first.
- Payload: 4·N bytes, each word sent MSB first.
- Trailing checksum byte only when the configuration macro is defined.

Byte transfer:
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- `in_ready` = 1 in CNT_HI, CNT_LO, DATA and CHK; 0 in all other states.

State machine (reset state CNT_HI):
- CNT_HI: accept byte → count[15:8]; go to CNT_LO.
- CNT_LO: accept byte → count[7:0].
  - N = 0: go to DONE.
  - N > 2^ADDR_W: go to ERROR.
  - Otherwise: go to DATA.
- DATA: shift each byte into a 24-bit assembly register. On the 4th byte of a word, register `imem_wdata` = {asm[23:0], in_data} and `imem_waddr` = word index, and pulse `imem_we` the next cycle. Then increment the word index; it equals N−1 at the last word and never wraps.
  - After the last byte of word N−1: go to FLUSH, or to CHK with the checksum enabled.
- FLUSH: the final `imem_we` pulse occurs in this cycle; go to DONE.
- CHK: see Configuration.
- DONE: `cpu_reset` = 0, `done` = 1. Stays here until reset; further stream bytes are not accepted.
- ERROR: `cpu_reset` = 1, `error` = 1. Stays here until reset.

Reset values: `in_ready` 0 while `reset` is low; `imem_we` 0; `imem_waddr` 0; `imem_wdata` 0; `cpu_reset` 1; `done` 0; `error` 0; state CNT_HI; all counters 0.

Reset mid-load: all state is discarded immediately. Words already written remain in memory. The next stream starts with a header.

## Timing
- In DATA, `in_ready` = 1 every cycle, so a word can be loaded every 4 cycles. Gaps of any length in `in_valid` are allowed.
- Write latency: `imem_we` is high exactly one cycle, the cycle after the accepting edge of the word's 4th byte. Address and data are stable during that cycle.
- Release: `cpu_reset` falls and `done` rises one cycle after the final `imem_we` cycle, on the edge that ends FLUSH. The last write is therefore committed before the processor leaves reset.
- N = 0: `done` = 1 and `cpu_reset` = 0 the cycle after the CNT_LO byte is accepted; no writes occur.
- Oversize N: `error` = 1 the cycle after the CNT_LO byte is accepted; no writes occur.
- `done` and `error` are never both 1.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHK state exists and a trailing checksum byte is expected.
  - The checksum is the XOR of all 4·N payload bytes; header bytes are excluded.
  - The final `imem_we` pulse occurs in the first CHK cycle.
  - Checksum byte equal to the running XOR: go to DONE.
  - Checksum byte not equal: go to ERROR, with `cpu_reset` held 1. Written words remain in memory.
  - N = 0 still goes directly to DONE; no checksum byte is expected.
- Not defined: the CHK state and XOR register are absent, and the last data byte leads to FLUSH.

## Test plan
- Header 00 03, then words 20020001, 20030001, 00431020 back-to-back with `in_valid` constant 1 → three `imem_we` pulses at addresses 0, 1, 2 spaced 4 cycles apart, with matching data. `done` rises one cycle after the 3rd pulse; `cpu_reset` falls on the same edge.
- Same image with `in_valid` toggling 1/0 each cycle → identical writes; each pulse occurs exactly one cycle after its 4th accepted byte.
- Header 00 00 → no writes; `done` = 1 and `cpu_reset` = 0 one cycle after the second byte. With ADDR_W = 6, header 00 41 (65) → `error` = 1, no writes, `in_ready` = 0, `cpu_reset` stays 1.
- Reset driven low after 6 payload bytes of a 2-word image → outputs return to reset values immediately. A fresh 1-word stream then writes address 0 and completes normally.
- With `IMEM_LOADER_CHECKSUM_EN`: word 12345678 followed by checksum 08 (12^34^56^78) → `done` = 1. The same word with checksum 09 → `error` = 1 and `cpu_reset` = 1, while address 0 still holds 12345678.
